// File: rtl/pipe_pkg.sv
// Shared encodings for the operand-forwarding pipeline register:
// forwarding slot indices and the out_fwd_sel source codes.
package pipe_pkg;

    localparam int NSLOT    = 3;
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // Slot k maps to select code k+1; code 0 means "regfile or held value".
    function automatic logic [1:0] slot_to_sel(input int slot);
        return 2'(slot + 1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational priority selector for one source operand: the lowest-numbered
// enabled slot whose non-zero address matches wins, otherwise the default data.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic [AW-1:0]           addr_i,
    input  logic [DATA_W-1:0]       dflt_data_i,
    input  logic [NSLOT-1:0]        fw_en_i,
    input  logic [NSLOT*AW-1:0]     fw_addr_i,
    input  logic [NSLOT*DATA_W-1:0] fw_data_i,
    output logic [DATA_W-1:0]       data_o,
    output logic [1:0]              sel_o
);

    logic found;

    always_comb begin
        data_o = dflt_data_i;
        sel_o  = FWD_RF;
        found  = 1'b0;
        // Register 0 is hard-wired, so it is never a forwarding target.
        for (int k = 0; k < NSLOT; k++) begin
            if (!found && fw_en_i[k] && (addr_i != '0) &&
                (fw_addr_i[k*AW +: AW] == addr_i)) begin
                data_o = fw_data_i[k*DATA_W +: DATA_W];
                sel_o  = slot_to_sel(k);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_fwd_reg.sv
// Pipeline stage register with operand forwarding; stalled operands keep
// re-forwarding so late producers still reach a held instruction.
module pipe_fwd_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int CTRL_W = 16,
    parameter int PAY_W  = 84
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [PAY_W-1:0]       in_payload,
    input  logic [NSRC*AW-1:0]     in_src_addr,
    input  logic [NSRC*DATA_W-1:0] in_src_data,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect_en,
    input  logic [DATA_W-1:0]      redirect_pc,
    input  logic [2:0]             fw_en,
    input  logic [3*AW-1:0]        fw_addr,
    input  logic [3*DATA_W-1:0]    fw_data,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_pc,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [PAY_W-1:0]       out_payload,
    output logic [NSRC*AW-1:0]     out_src_addr,
    output logic [NSRC*DATA_W-1:0] out_src_data,
    output logic [NSRC*2-1:0]      out_fwd_sel
);

    logic                   valid_q, valid_d;
    logic [DATA_W-1:0]      pc_q, pc_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic [PAY_W-1:0]       pay_q, pay_d;
    logic [NSRC*AW-1:0]     addr_q, addr_d;
    logic [NSRC*DATA_W-1:0] data_q, data_d;
    logic [NSRC*2-1:0]      sel_q, sel_d;

    logic [AW-1:0]     lk_addr [NSRC];
    logic [DATA_W-1:0] lk_dflt [NSRC];
    logic [DATA_W-1:0] fs_data [NSRC];
    logic [1:0]        fs_sel  [NSRC];

    // While stalled the selectors look at the held operand instead of the new one.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign lk_addr[i] = stall ? addr_q[i*AW +: AW]         : in_src_addr[i*AW +: AW];
        assign lk_dflt[i] = stall ? data_q[i*DATA_W +: DATA_W] : in_src_data[i*DATA_W +: DATA_W];

        fwd_select #(
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_fwd_select (
            .addr_i      (lk_addr[i]),
            .dflt_data_i (lk_dflt[i]),
            .fw_en_i     (fw_en),
            .fw_addr_i   (fw_addr),
            .fw_data_i   (fw_data),
            .data_o      (fs_data[i]),
            .sel_o       (fs_sel[i])
        );
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        pay_d   = pay_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            ctrl_d  = '0;
            pay_d   = '0;
            addr_d  = '0;
            data_d  = '0;
            sel_d   = '0;
        end else if (stall) begin
            // A miss leaves both the held value and its original select code.
            for (int i = 0; i < NSRC; i++) begin
                if (fs_sel[i] != FWD_RF) begin
                    data_d[i*DATA_W +: DATA_W] = fs_data[i];
                    sel_d[i*2 +: 2]            = fs_sel[i];
                end
            end
        end else begin
            valid_d = in_valid;
            pc_d    = redirect_en ? redirect_pc : in_pc;
            ctrl_d  = in_ctrl;
            pay_d   = in_payload;
            addr_d  = in_src_addr;
            for (int i = 0; i < NSRC; i++) begin
                data_d[i*DATA_W +: DATA_W] = fs_data[i];
                sel_d[i*2 +: 2]            = fs_sel[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            pay_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            pay_q   <= pay_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_ctrl     = ctrl_q;
    assign out_payload  = pay_q;
    assign out_src_addr = addr_q;
    assign out_src_data = data_q;
    assign out_fwd_sel  = sel_q;

endmodule

// File: tb/tb_pipe_fwd_reg.sv
// Self-checking bench for pipe_fwd_reg: directed forwarding/stall/flush/reset
// cases followed by random traffic against a behavioural model.
module tb_pipe_fwd_reg;

    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int NSRC   = 2;
    localparam int CTRL_W = 16;
    localparam int PAY_W  = 84;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [DATA_W-1:0]      in_pc;
    logic [CTRL_W-1:0]      in_ctrl;
    logic [PAY_W-1:0]       in_payload;
    logic [NSRC*AW-1:0]     in_src_addr;
    logic [NSRC*DATA_W-1:0] in_src_data;
    logic                   stall;
    logic                   flush;
    logic                   redirect_en;
    logic [DATA_W-1:0]      redirect_pc;
    logic [2:0]             fw_en;
    logic [3*AW-1:0]        fw_addr;
    logic [3*DATA_W-1:0]    fw_data;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_pc;
    logic [CTRL_W-1:0]      out_ctrl;
    logic [PAY_W-1:0]       out_payload;
    logic [NSRC*AW-1:0]     out_src_addr;
    logic [NSRC*DATA_W-1:0] out_src_data;
    logic [NSRC*2-1:0]      out_fwd_sel;

    pipe_fwd_reg #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .NSRC   (NSRC),
        .CTRL_W (CTRL_W),
        .PAY_W  (PAY_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_ctrl      (in_ctrl),
        .in_payload   (in_payload),
        .in_src_addr  (in_src_addr),
        .in_src_data  (in_src_data),
        .stall        (stall),
        .flush        (flush),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .fw_en        (fw_en),
        .fw_addr      (fw_addr),
        .fw_data      (fw_data),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_ctrl     (out_ctrl),
        .out_payload  (out_payload),
        .out_src_addr (out_src_addr),
        .out_src_data (out_src_data),
        .out_fwd_sel  (out_fwd_sel)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: what the stage should be presenting.
    logic              m_valid;
    logic [DATA_W-1:0] m_pc;
    logic [CTRL_W-1:0] m_ctrl;
    logic [PAY_W-1:0]  m_pay;
    logic [AW-1:0]     m_addr [NSRC];
    logic [DATA_W-1:0] m_data [NSRC];
    int                m_sel  [NSRC];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_pc    = '0;
        m_ctrl  = '0;
        m_pay   = '0;
        for (int i = 0; i < NSRC; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
            m_sel[i]  = 0;
        end
    endtask

    // Index of the winning forwarding slot for an address, -1 if none.
    function automatic int winner(input logic [AW-1:0] a);
        if (a == 0) return -1;
        for (int k = 0; k < 3; k++)
            if (fw_en[k] && fw_addr[k*AW +: AW] == a) return k;
        return -1;
    endfunction

    task automatic compare_all(input string tag);
        logic [NSRC*AW-1:0]     ea;
        logic [NSRC*DATA_W-1:0] ed;
        logic [NSRC*2-1:0]      es;
        for (int i = 0; i < NSRC; i++) begin
            ea[i*AW +: AW]         = m_addr[i];
            ed[i*DATA_W +: DATA_W] = m_data[i];
            es[i*2 +: 2]           = 2'(m_sel[i]);
        end
        chk({tag, ".valid"}, 128'(out_valid),    128'(m_valid));
        chk({tag, ".pc"},    128'(out_pc),       128'(m_pc));
        chk({tag, ".ctrl"},  128'(out_ctrl),     128'(m_ctrl));
        chk({tag, ".pay"},   128'(out_payload),  128'(m_pay));
        chk({tag, ".addr"},  128'(out_src_addr), 128'(ea));
        chk({tag, ".data"},  128'(out_src_data), 128'(ed));
        chk({tag, ".sel"},   128'(out_fwd_sel),  128'(es));
    endtask

    // Advance the model with the current inputs, clock once, compare.
    task automatic step(input string tag);
        int w;
        if (flush) begin
            model_clear();
        end else if (stall) begin
            for (int i = 0; i < NSRC; i++) begin
                w = winner(m_addr[i]);
                if (w >= 0) begin
                    m_data[i] = fw_data[w*DATA_W +: DATA_W];
                    m_sel[i]  = w + 1;
                end
            end
        end else begin
            m_valid = in_valid;
            m_pc    = redirect_en ? redirect_pc : in_pc;
            m_ctrl  = in_ctrl;
            m_pay   = in_payload;
            for (int i = 0; i < NSRC; i++) begin
                m_addr[i] = in_src_addr[i*AW +: AW];
                w = winner(m_addr[i]);
                m_data[i] = (w >= 0) ? fw_data[w*DATA_W +: DATA_W] : in_src_data[i*DATA_W +: DATA_W];
                m_sel[i]  = w + 1;
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic quiet_inputs();
        in_valid    = 1'b0;
        in_pc       = '0;
        in_ctrl     = '0;
        in_payload  = '0;
        in_src_addr = '0;
        in_src_data = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        fw_en       = '0;
        fw_addr     = '0;
        fw_data     = '0;
    endtask

    task automatic rand_inputs();
        in_valid    = 1'($urandom);
        in_pc       = $urandom;
        in_ctrl     = 16'($urandom);
        in_payload  = PAY_W'({$urandom, $urandom, $urandom});
        for (int i = 0; i < NSRC; i++) begin
            in_src_addr[i*AW +: AW]         = AW'($urandom_range(0, 7));
            in_src_data[i*DATA_W +: DATA_W] = $urandom;
        end
        stall       = ($urandom_range(0, 3) == 0);
        flush       = ($urandom_range(0, 9) == 0);
        redirect_en = ($urandom_range(0, 4) == 0);
        redirect_pc = $urandom;
        fw_en       = 3'($urandom);
        for (int k = 0; k < 3; k++) begin
            fw_addr[k*AW +: AW]         = AW'($urandom_range(0, 7));
            fw_data[k*DATA_W +: DATA_W] = $urandom;
        end
    endtask

    initial begin
        quiet_inputs();
        model_clear();
        reset = 1'b0;
        #12;
        compare_all("reset");
        reset = 1'b1;

        // EX and MEM both hit address 3: EX wins.
        in_valid = 1'b1;
        in_pc = 32'h100;
        in_src_addr[0 +: AW] = 5'd3;
        in_src_data[0 +: DATA_W] = 32'h1234;
        fw_en = 3'b011;
        fw_addr = {5'd0, 5'd3, 5'd3};
        fw_data = {32'h0, 32'hB, 32'hA};
        step("ex_over_mem");
        chk("ex_over_mem.d0", 128'(out_src_data[0 +: DATA_W]), 128'h0A);
        chk("ex_over_mem.s0", 128'(out_fwd_sel[1:0]), 128'd1);

        // WB writing register 0 is ignored.
        quiet_inputs();
        in_valid = 1'b1;
        fw_en = 3'b100;
        fw_addr = {5'd0, 5'd0, 5'd0};
        fw_data = {32'hFF, 32'h0, 32'h0};
        step("wb_r0");
        chk("wb_r0.d0", 128'(out_src_data[0 +: DATA_W]), 128'h0);
        chk("wb_r0.s0", 128'(out_fwd_sel[1:0]), 128'd0);

        // Load src1=r7, then stall three cycles with WB writing r7 in the second.
        quiet_inputs();
        in_valid = 1'b1;
        in_pc = 32'h200;
        in_ctrl = 16'hC0DE;
        in_src_addr[AW +: AW] = 5'd7;
        in_src_data[DATA_W +: DATA_W] = 32'h11;
        step("stall_load");
        quiet_inputs();
        stall = 1'b1;
        in_pc = 32'hDEAD;
        step("stall_c1");
        fw_en = 3'b100;
        fw_addr = {5'd7, 5'd0, 5'd0};
        fw_data = {32'h55, 32'h0, 32'h0};
        step("stall_c2");
        fw_en = 3'b000;
        step("stall_c3");
        chk("stall.d1",  128'(out_src_data[DATA_W +: DATA_W]), 128'h55);
        chk("stall.s1",  128'(out_fwd_sel[3:2]), 128'd3);
        chk("stall.pc",  128'(out_pc), 128'h200);
        chk("stall.ctl", 128'(out_ctrl), 128'hC0DE);

        // Flush beats stall.
        flush = 1'b1;
        step("flush_stall");
        chk("flush_stall.v", 128'(out_valid), 128'd0);

        // Redirect replaces the PC.
        quiet_inputs();
        in_valid = 1'b1;
        in_pc = 32'h100;
        redirect_en = 1'b1;
        redirect_pc = 32'h400;
        step("redirect");
        chk("redirect.pc", 128'(out_pc), 128'h400);

        // Async reset in the middle of a stall, released between edges.
        quiet_inputs();
        in_valid = 1'b1;
        in_pc = 32'h300;
        in_src_addr = {5'd2, 5'd1};
        in_src_data = {32'h22, 32'h11};
        step("pre_reset");
        stall = 1'b1;
        step("pre_reset_stall");
        #1;
        reset = 1'b0;
        #1;
        model_clear();
        compare_all("async_reset");
        #1;
        reset = 1'b1;
        stall = 1'b0;
        in_pc = 32'h304;
        step("post_reset");
        chk("post_reset.pc", 128'(out_pc), 128'h304);

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_fwd_reg.md
PIPE_FWD_REG -- requirements
Module: pipe_fwd_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/PC width.
REQ-002 SHALL have parameter AW, default 5, register-address width.
REQ-003 SHALL have parameter NSRC, default 2, number of source operands (1..4).
REQ-004 SHALL have parameter CTRL_W, default 16, control-field width.
REQ-005 SHALL have parameter PAY_W, default 84, pass-through payload width.
REQ-006 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: in_valid in 1; in_pc in DATA_W; in_ctrl in CTRL_W; in_payload in PAY_W.
REQ-008 SHALL have ports: in_src_addr in NSRC*AW; in_src_data in NSRC*DATA_W, register-file read values.
REQ-009 SHALL have ports: stall in 1, hold stage; flush in 1, insert bubble.
REQ-010 SHALL have ports: redirect_en in 1; redirect_pc in DATA_W, replaces captured PC.
REQ-011 SHALL have ports: fw_en in 3; fw_addr in 3*AW; fw_data in 3*DATA_W; slot 0 = EX, 1 = MEM, 2 = WB.
REQ-012 SHALL have ports: out_valid out 1; out_pc out DATA_W; out_ctrl out CTRL_W; out_payload out PAY_W.
REQ-013 SHALL have ports: out_src_addr out NSRC*AW; out_src_data out NSRC*DATA_W; out_fwd_sel out NSRC*2, source of last operand load (0 = regfile/held, 1 = EX, 2 = MEM, 3 = WB).

Function
REQ-014 SHALL, on each rising edge with flush=0 and stall=0, capture all inputs into outputs; latency exactly 1 cycle.
REQ-015 SHALL set out_valid, out_ctrl, out_pc, out_payload, out_src_addr, out_src_data, out_fwd_sel to 0 on a flush edge.
REQ-016 SHALL give flush priority over stall and over redirect_en.
REQ-017 SHALL capture redirect_pc instead of in_pc when redirect_en=1, stall=0, flush=0.
REQ-018 SHALL, per source i in a load cycle, select the lowest-numbered slot k with fw_en[k]=1, fw_addr[k]==in_src_addr[i], fw_addr[k]!=0; else in_src_data[i].
REQ-019 SHALL never forward for address 0 from any slot, including WB.
REQ-020 SHALL, when stall=1 and flush=0, hold out_valid, out_pc, out_ctrl, out_payload, out_src_addr unchanged.
REQ-021 SHALL, during stall, re-forward each held operand: compare out_src_addr[i] against slots per REQ-018/019; on hit load fw_data[k] and set out_fwd_sel[i]=k+1; on miss keep value and out_fwd_sel[i].
REQ-022 SHALL treat forwarding with in_valid=0 identically; out_valid follows in_valid.
REQ-023 SHALL resolve each source independently; two sources with same address receive the same value.
REQ-024 SHALL be free of combinational paths from inputs to outputs.

Reset
REQ-025 SHALL drive every output to 0 asynchronously while reset=0, independent of clk.
REQ-026 SHALL resume normal capture on the first rising edge after reset returns to 1.

Structure
REQ-027 SHALL place slot indices (EX=0, MEM=1, WB=2) and fwd_sel encodings in shared package pipe_pkg.
REQ-028 SHALL instantiate one sub-module, fwd_select, NSRC times: combinational priority selector (addr, default data, 3 slots -> data, sel).

Verification
REQ-029 SHALL cover: src0 addr 3, EX and MEM both write 3 (0xA, 0xB) -> out_src_data[0]=0xA, out_fwd_sel[0]=1.
REQ-030 SHALL cover: WB writes addr 0 data 0xFF, src addr 0, regfile 0 -> out_src_data=0, out_fwd_sel=0.
REQ-031 SHALL cover: stall 3 cycles, src1 addr 7, WB writes 7=0x55 in cycle 2 -> held operand becomes 0x55, sel=3, other outputs unchanged.
REQ-032 SHALL cover: flush and stall both 1 -> all outputs 0 next edge.
REQ-033 SHALL cover: redirect_en=1, redirect_pc=0x400, in_pc=0x100 -> out_pc=0x400.
REQ-034 SHALL cover: reset low mid-stall between edges -> outputs 0 immediately; first edge after release captures inputs.
